// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: opcodes, FSM states and
// sizing constants for the packet engine.
package uart_alu_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int HDR_BYTES     = 4;
  localparam int OPERAND_BYTES = 4;

  typedef enum logic [7:0] {
    OPC_ADD  = 8'h01,
    OPC_ECHO = 8'hEC
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    HDR_RSVD,
    HDR_LEN_L,
    HDR_LEN_H,
    ECHO,
    ADD,
    DRAIN,
    RESULT
  } state_e;

endpackage

// File: rtl/uart_alu_result_ser.sv
// uart_alu_result_ser: loads a 32-bit word and streams it LSB first.
// Ports: load/word in, AXI-Stream byte master out, done on last accept.
module uart_alu_result_ser
  import uart_alu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [31:0]           word_i,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  done_o
);

  logic [31:0] word_q;
  logic [1:0]  cnt_q;
  logic        valid_q;
  logic        fire;

  assign fire   = valid_q && m_axis_tready;
  assign done_o = fire &&
                  (cnt_q == 2'(OPERAND_BYTES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      word_q  <= word_i;
      cnt_q   <= '0;
      valid_q <= 1'b1;
    end else if (fire) begin
      word_q <= {8'h00, word_q[31:8]};
      cnt_q  <= cnt_q + 2'd1;
      if (done_o) valid_q <= 1'b0;
    end
  end

  assign m_axis_tdata  = word_q[7:0];
  assign m_axis_tvalid = valid_q;

endmodule

// File: rtl/uart_alu_packet_engine.sv
// uart_alu_packet_engine: parses RX packets (opc, rsvd, len) and
// answers echo / 32-bit add on TX. Ports: RX/TX AXI-Stream, busy, bad_opcode.
module uart_alu_packet_engine
  import uart_alu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy_o,
  output logic                  bad_opcode_o
);

  state_e      state_q, state_d;
  logic [7:0]  opc_q, opc_d;
  logic [7:0]  len_l_q, len_l_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] acc_q, acc_d;
  logic [23:0] sh_q, sh_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  echo_q, echo_d;
  logic        ev_q, ev_d;
  logic        bad_q, bad_d;
  logic        live_q;

  logic        rx_fire;
  logic        last;
  logic [15:0] len;
  logic [15:0] hdr_rem;
  logic        ser_load;
  logic        ser_valid;
  logic        ser_done;
  logic [7:0]  ser_data;

  assign rx_fire = s_axis_tvalid && s_axis_tready;
  assign last    = (rem_q == 16'd1);
  assign len     = {s_axis_tdata, len_l_q};
  assign hdr_rem = (len < 16'(HDR_BYTES)) ? '0
                 : len - 16'(HDR_BYTES);

  // Load on the entry edge with the post-add value,
  // so the first result byte is valid right after entry.
  assign ser_load = (state_d == RESULT) &&
                    (state_q != RESULT);

  always_comb begin
    state_d       = state_q;
    opc_d         = opc_q;
    len_l_d       = len_l_q;
    rem_d         = rem_q;
    acc_d         = acc_q;
    sh_d          = sh_q;
    idx_d         = idx_q;
    echo_d        = echo_q;
    ev_d          = ev_q && !m_axis_tready;
    bad_d         = 1'b0;
    s_axis_tready = 1'b0;
    unique case (state_q)
      IDLE: begin
        // no new header while an echo byte is pending
        s_axis_tready = live_q && !ev_q;
        if (rx_fire) begin
          opc_d   = s_axis_tdata;
          state_d = HDR_RSVD;
        end
      end
      HDR_RSVD: begin
        s_axis_tready = 1'b1;
        if (rx_fire) state_d = HDR_LEN_L;
      end
      HDR_LEN_L: begin
        s_axis_tready = 1'b1;
        if (rx_fire) begin
          len_l_d = s_axis_tdata;
          state_d = HDR_LEN_H;
        end
      end
      HDR_LEN_H: begin
        s_axis_tready = 1'b1;
        if (rx_fire) begin
          rem_d = hdr_rem;
          if (opc_q == OPC_ECHO) begin
            state_d = (hdr_rem == '0) ? IDLE : ECHO;
          end else if (opc_q == OPC_ADD) begin
            acc_d   = '0;
            sh_d    = '0;
            idx_d   = '0;
            state_d = (hdr_rem == '0) ? RESULT : ADD;
          end else begin
            bad_d   = 1'b1;
            state_d = (hdr_rem == '0) ? IDLE : DRAIN;
          end
        end
      end
      ECHO: begin
        s_axis_tready = !ev_q || m_axis_tready;
        if (rx_fire) begin
          echo_d = s_axis_tdata;
          ev_d   = 1'b1;
          rem_d  = rem_q - 16'd1;
          if (last) state_d = IDLE;
        end
      end
      ADD: begin
        s_axis_tready = 1'b1;
        if (rx_fire) begin
          sh_d  = {s_axis_tdata, sh_q[23:8]};
          idx_d = idx_q + 2'd1;
          rem_d = rem_q - 16'd1;
          if (idx_q == 2'(OPERAND_BYTES - 1))
            acc_d = acc_q + {s_axis_tdata, sh_q};
          if (last) state_d = RESULT;
        end
      end
      DRAIN: begin
        s_axis_tready = 1'b1;
        if (rx_fire) begin
          rem_d = rem_q - 16'd1;
          if (last) state_d = IDLE;
        end
      end
      RESULT: begin
        if (ser_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      opc_q   <= '0;
      len_l_q <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      echo_q  <= '0;
      ev_q    <= 1'b0;
      bad_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      len_l_q <= len_l_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      echo_q  <= echo_d;
      ev_q    <= ev_d;
      bad_q   <= bad_d;
      live_q  <= 1'b1;
    end
  end

  uart_alu_result_ser u_ser (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .load_i        (ser_load),
    .word_i        (acc_d),
    .m_axis_tdata  (ser_data),
    .m_axis_tvalid (ser_valid),
    .m_axis_tready (m_axis_tready),
    .done_o        (ser_done)
  );

  // echo register and serializer are never valid together
  assign m_axis_tvalid = ev_q || ser_valid;
  assign m_axis_tdata  = ser_valid ? ser_data : echo_q;
  assign busy_o        = (state_q != IDLE);
  assign bad_opcode_o  = bad_q;

endmodule
